// File: rtl/pwm_pkg.sv
// Shared PWM definitions: frame length common to generator and decoder,
// duty width, and the decoder state encoding.
package pwm_pkg;

  // Frame length in pwm_clk cycles, identical on the generator side.
  localparam int PWM_PERIOD = 255;

  // Width of the duty value carried between generator and decoder.
  localparam int DUTY_W = 8;

  // Decoder state machine states.
  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    STEADY  = 2'd2
  } dec_state_t;

  // Duty reported while the input sits at a constant level.
  function automatic logic [DUTY_W-1:0] steady_duty(input logic level);
    return level ? {DUTY_W{1'b1}} : {DUTY_W{1'b0}};
  endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Input conditioner for the asynchronous PWM line: a SYNC_STAGES-deep
// synchronizer followed by a previous-value flop for edge detection.
// SYNC_STAGES must be at least 2.
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pwm,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync_chain;
  logic                   r_prev;
  logic                   w_sync;

  assign w_sync = r_sync_chain[SYNC_STAGES-1];

  // Shift the raw input through the synchronizer and remember the last synced value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync_chain <= '0;
      r_prev       <= 1'b0;
    end else begin
      r_sync_chain <= {r_sync_chain[SYNC_STAGES-2:0], i_pwm};
      r_prev       <= w_sync;
    end
  end

  assign o_sync = w_sync;
  assign o_rise = w_sync & ~r_prev;
  assign o_fall = ~w_sync & r_prev;

endmodule

// File: rtl/pwm_decoder.sv
// Recovers the duty value from an incoming fixed-period PWM waveform.
// A rising edge closes the previous frame: if the frame lasted exactly
// PERIOD cycles its high time is reported, otherwise a period error is
// flagged. An input that stops toggling for TIMEOUT cycles is reported as
// constant (duty 0 or all-ones), re-sampled once per PERIOD.
//
// Output handshake: duty_valid is a single-cycle strobe with no back-pressure;
// duty_out is written on that same edge and held until the next strobe.
// period_error is a single-cycle strobe and never coincides with duty_valid.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int PERIOD      = PWM_PERIOD,
  parameter int TIMEOUT     = 510,
  parameter int SYNC_STAGES = 2
) (
  input  logic              pwm_clk,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_valid,
  output logic              locked,
  output logic              period_error,
  output dec_state_t        o_dbg_state
);

  localparam int                CNT_W     = $clog2(TIMEOUT + 1);
  localparam int                HIGH_W    = 9;
  localparam logic [CNT_W-1:0]  PERIOD_C  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [HIGH_W-1:0] HIGH_ONE  = HIGH_W'(1);
  localparam logic [HIGH_W-1:0] HIGH_MAX  = {HIGH_W{1'b1}};

  // Conditioned input
  logic w_sync;
  logic w_rise;
  logic w_fall;

  // Registered state
  dec_state_t        r_state;
  logic [CNT_W-1:0]  r_per_cnt;
  logic [HIGH_W-1:0] r_high_cnt;
  logic [DUTY_W-1:0] r_duty;
  logic              r_valid;
  logic              r_locked;
  logic              r_perr;

  // Next-state values
  dec_state_t        w_state_nxt;
  logic [CNT_W-1:0]  w_per_free;
  logic [CNT_W-1:0]  w_per_nxt;
  logic [HIGH_W-1:0] w_high_nxt;
  logic [DUTY_W-1:0] w_duty_nxt;
  logic              w_valid_nxt;
  logic              w_locked_nxt;
  logic              w_perr_nxt;
  logic              w_per_at_period;
  logic              w_per_at_timeout;

  pwm_in_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_in_sync (
    .i_clk  (pwm_clk),
    .i_rst  (reset),
    .i_pwm  (pwm_in),
    .o_sync (w_sync),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Decisions are taken on the edge where the registered count holds the
  // threshold, so a frame of exactly PERIOD cycles compares equal on its
  // closing rise.
  assign w_per_at_period  = (r_per_cnt == PERIOD_C);
  assign w_per_at_timeout = (r_per_cnt == TIMEOUT_C);

  // Free-running period count: restart on a rise, otherwise count up and park at TIMEOUT.
  always_comb begin
    w_per_free = r_per_cnt;
    if (w_rise) begin
      w_per_free = CNT_ONE;
    end else if (!w_per_at_timeout) begin
      w_per_free = r_per_cnt + CNT_ONE;
    end
  end

  // High-time count: restart on a rise, count every cycle the input is high.
  always_comb begin
    w_high_nxt = r_high_cnt;
    if (w_rise) begin
      w_high_nxt = HIGH_ONE;
    end else if (w_sync && (r_high_cnt != HIGH_MAX)) begin
      w_high_nxt = r_high_cnt + HIGH_ONE;
    end
  end

  // Decoder FSM: next state, period-counter overrides and output values.
  always_comb begin
    w_state_nxt  = r_state;
    w_per_nxt    = w_per_free;
    w_duty_nxt   = r_duty;
    w_valid_nxt  = 1'b0;
    w_locked_nxt = r_locked;
    w_perr_nxt   = 1'b0;

    unique case (r_state)
      ACQUIRE: begin
        // First rise only opens a frame; nothing can be reported yet.
        if (w_rise) begin
          w_state_nxt = MEASURE;
        end else if (w_per_at_timeout) begin
          w_state_nxt  = STEADY;
          w_per_nxt    = CNT_ONE;
          w_duty_nxt   = steady_duty(w_sync);
          w_valid_nxt  = 1'b1;
          w_locked_nxt = 1'b1;
        end
      end

      MEASURE: begin
        // A rise always wins over a simultaneous timeout.
        if (w_rise) begin
          if (w_per_at_period) begin
            w_duty_nxt   = r_high_cnt[DUTY_W-1:0];
            w_valid_nxt  = 1'b1;
            w_locked_nxt = 1'b1;
          end else begin
            w_perr_nxt   = 1'b1;
            w_locked_nxt = 1'b0;
          end
        end else if (w_per_at_timeout) begin
          w_state_nxt  = STEADY;
          w_per_nxt    = CNT_ONE;
          w_duty_nxt   = steady_duty(w_sync);
          w_valid_nxt  = 1'b1;
          w_locked_nxt = 1'b1;
        end
      end

      STEADY: begin
        // Any edge ends the constant-level interpretation; the partial
        // frame that follows is never reported.
        if (w_rise) begin
          w_state_nxt  = MEASURE;
          w_locked_nxt = 1'b0;
        end else if (w_fall) begin
          w_state_nxt  = ACQUIRE;
          w_locked_nxt = 1'b0;
        end else if (w_per_at_period) begin
          w_per_nxt   = CNT_ONE;
          w_duty_nxt  = steady_duty(w_sync);
          w_valid_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt  = ACQUIRE;
        w_locked_nxt = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge pwm_clk or posedge reset) begin
    if (reset) begin
      r_state <= ACQUIRE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Period and high-time counters.
  always_ff @(posedge pwm_clk or posedge reset) begin
    if (reset) begin
      r_per_cnt  <= '0;
      r_high_cnt <= '0;
    end else begin
      r_per_cnt  <= w_per_nxt;
      r_high_cnt <= w_high_nxt;
    end
  end

  // Output registers.
  always_ff @(posedge pwm_clk or posedge reset) begin
    if (reset) begin
      r_duty   <= '0;
      r_valid  <= 1'b0;
      r_locked <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_duty   <= w_duty_nxt;
      r_valid  <= w_valid_nxt;
      r_locked <= w_locked_nxt;
      r_perr   <= w_perr_nxt;
    end
  end

  assign duty_out     = r_duty;
  assign duty_valid   = r_valid;
  assign locked       = r_locked;
  assign period_error = r_perr;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: frame-vector table, hand-written constant-level and
// reset sequences, and a randomized frame stream checked against an
// event-list model built from rise times and high-time counts.
module tb_pwm_decoder;
  import pwm_pkg::*;

  localparam int PERIOD      = 255;
  localparam int TIMEOUT     = 510;
  localparam int SYNC_STAGES = 2;

  logic       pwm_clk = 1'b0;
  logic       reset;
  logic       pwm_in;
  logic [7:0] duty_out;
  logic       duty_valid;
  logic       locked;
  logic       period_error;
  dec_state_t dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    int         hi;
    int         lo;
    logic       exp_valid;
    logic       exp_err;
    logic [7:0] exp_duty;
    logic       exp_locked;
  } frame_vec_t;

  frame_vec_t vecs[15];

  // ---------------- clock / reset ----------------
  always #5 pwm_clk = ~pwm_clk;

  pwm_decoder #(
    .PERIOD      (PERIOD),
    .TIMEOUT     (TIMEOUT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .pwm_clk      (pwm_clk),
    .reset        (reset),
    .pwm_in       (pwm_in),
    .duty_out     (duty_out),
    .duty_valid   (duty_valid),
    .locked       (locked),
    .period_error (period_error),
    .o_dbg_state  (dbg_state)
  );

  initial begin
    #5_000_000;
    n_err++;
    $display("FAIL watchdog: time limit reached, got t=%0t required finish earlier", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // duty_valid and period_error must never coincide.
  always @(negedge pwm_clk) begin
    if (reset === 1'b0) check("excl_valid_perr", {31'd0, duty_valid & period_error}, 32'd0);
  end

  // ---------------- driver tasks ----------------
  // One input sample: drive at the falling edge, return just after the rising edge.
  task automatic tick(input logic v);
    @(negedge pwm_clk);
    pwm_in = v;
    @(posedge pwm_clk);
    #1;
  endtask

  task automatic apply_reset();
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(posedge pwm_clk);
    #1;
    check("rst_duty",   duty_out, 0);
    check("rst_valid",  duty_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_perr",   period_error, 0);
    check("rst_state",  dbg_state, ACQUIRE);
    reset = 1'b0;
  endtask

  // One frame: the rise opening it closes the previous frame, whose result
  // must appear exactly SYNC_STAGES edges after the first high sample.
  task automatic drive_frame(input frame_vec_t f, input string tag);
    for (int c = 0; c < f.hi + f.lo; c++) begin
      tick(c < f.hi);
      if (c == SYNC_STAGES) begin
        check({tag, "_valid"},  duty_valid, f.exp_valid);
        check({tag, "_perr"},   period_error, f.exp_err);
        check({tag, "_duty"},   duty_out, f.exp_duty);
        check({tag, "_locked"}, locked, f.exp_locked);
      end else begin
        check({tag, "_quiet_valid"}, duty_valid, 0);
        check({tag, "_quiet_perr"},  period_error, 0);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_first;

    reset  = 1'b1;
    pwm_in = 1'b0;

    // ---- table: duty 100, duty 1, duty 254, duty 80 with one 200-cycle frame ----
    vecs[0]  = '{100, 155, 1'b0, 1'b0, 8'd0,   1'b0};
    vecs[1]  = '{100, 155, 1'b1, 1'b0, 8'd100, 1'b1};
    vecs[2]  = '{100, 155, 1'b1, 1'b0, 8'd100, 1'b1};
    vecs[3]  = '{100, 155, 1'b1, 1'b0, 8'd100, 1'b1};
    vecs[4]  = '{1,   254, 1'b1, 1'b0, 8'd100, 1'b1};
    vecs[5]  = '{1,   254, 1'b1, 1'b0, 8'd1,   1'b1};
    vecs[6]  = '{1,   254, 1'b1, 1'b0, 8'd1,   1'b1};
    vecs[7]  = '{254, 1,   1'b1, 1'b0, 8'd1,   1'b1};
    vecs[8]  = '{254, 1,   1'b1, 1'b0, 8'd254, 1'b1};
    vecs[9]  = '{254, 1,   1'b1, 1'b0, 8'd254, 1'b1};
    vecs[10] = '{80,  175, 1'b1, 1'b0, 8'd254, 1'b1};
    vecs[11] = '{80,  175, 1'b1, 1'b0, 8'd80,  1'b1};
    vecs[12] = '{80,  120, 1'b1, 1'b0, 8'd80,  1'b1};
    vecs[13] = '{80,  175, 1'b0, 1'b1, 8'd80,  1'b0};
    vecs[14] = '{80,  175, 1'b1, 1'b0, 8'd80,  1'b1};

    apply_reset();
    for (int k = 0; k < 10; k++) begin
      tick(1'b0);
      check("idle_valid", duty_valid, 0);
    end
    for (int i = 0; i < 15; i++) begin
      drive_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // ---- held low: timeout reports duty 0, then once per PERIOD ----
    apply_reset();
    t_first = TIMEOUT + 1;
    for (int k = 1; k <= 1100; k++) begin
      tick(1'b0);
      check("low_valid",  duty_valid, (k >= t_first) && ((k - t_first) % PERIOD == 0));
      check("low_locked", locked, k >= t_first);
      check("low_duty",   duty_out, 0);
    end

    // ---- held high, then fall, then duty 50 ----
    apply_reset();
    t_first = SYNC_STAGES + 1 + TIMEOUT;
    for (int k = 1; k <= 1100; k++) begin
      tick(1'b1);
      check("high_valid",  duty_valid, (k >= t_first) && ((k - t_first) % PERIOD == 0));
      check("high_locked", locked, k >= t_first);
      check("high_duty",   duty_out, (k >= t_first) ? 255 : 0);
      check("high_perr",   period_error, 0);
    end
    for (int k = 1101; k <= 1200; k++) begin
      tick(1'b0);
      check("fall_valid",  duty_valid, 0);
      check("fall_locked", locked, k < 1101 + SYNC_STAGES);
      if (k >= 1101 + SYNC_STAGES) check("fall_state", dbg_state, ACQUIRE);
    end
    drive_frame('{50, 205, 1'b0, 1'b0, 8'd255, 1'b0}, "d50_first");
    drive_frame('{50, 205, 1'b1, 1'b0, 8'd50,  1'b1}, "d50_a");
    drive_frame('{50, 205, 1'b1, 1'b0, 8'd50,  1'b1}, "d50_b");

    // ---- reset in the middle of a duty-200 frame ----
    apply_reset();
    for (int k = 0; k < 5; k++) tick(1'b0);
    drive_frame('{200, 55, 1'b0, 1'b0, 8'd0,   1'b0}, "d200_first");
    drive_frame('{200, 55, 1'b1, 1'b0, 8'd200, 1'b1}, "d200_a");
    for (int c = 0; c < 120; c++) begin
      tick(1'b1);
      check("d200_part_valid", duty_valid, c == SYNC_STAGES);
    end
    check("d200_part_duty", duty_out, 200);
    #2 reset = 1'b1;
    #1;
    check("midrst_duty",   duty_out, 0);
    check("midrst_valid",  duty_valid, 0);
    check("midrst_locked", locked, 0);
    check("midrst_perr",   period_error, 0);
    check("midrst_state",  dbg_state, ACQUIRE);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1);
      check("inrst_valid", duty_valid, 0);
      check("inrst_duty",  duty_out, 0);
    end
    reset = 1'b0;
    for (int k = 0; k < 132; k++) begin
      tick(k < 77);
      check("rel_valid",  duty_valid, 0);
      check("rel_perr",   period_error, 0);
      check("rel_locked", locked, 0);
      check("rel_duty",   duty_out, 0);
    end
    drive_frame('{200, 55, 1'b0, 1'b1, 8'd0,   1'b0}, "rel_short");
    drive_frame('{200, 55, 1'b1, 1'b0, 8'd200, 1'b1}, "rel_full_a");
    drive_frame('{200, 55, 1'b1, 1'b0, 8'd200, 1'b1}, "rel_full_b");

    // ---- randomized frame stream against an event-list model ----
    begin
      bit w[$];
      int rises[$];
      int ev[];
      logic exp_locked;
      logic prev;

      apply_reset();
      repeat ($urandom_range(5, 50)) w.push_back(1'b0);
      for (int f = 0; f < 30; f++) begin
        int len;
        int hi;
        if ($urandom_range(0, 9) < 8) len = PERIOD;
        else len = $urandom_range(3, 400);
        hi = $urandom_range(1, len - 1);
        repeat (hi) w.push_back(1'b1);
        repeat (len - hi) w.push_back(1'b0);
      end
      repeat (3) w.push_back(1'b1);
      repeat (20) w.push_back(1'b0);

      // Model: every rise closes the previous frame; a frame exactly PERIOD
      // long reports its high time, any other length is a period error.
      // The very first rise only opens a frame.
      ev = new[w.size()];
      foreach (ev[i]) ev[i] = 0;
      prev = 1'b0;
      for (int i = 0; i < w.size(); i++) begin
        if (w[i] && !prev) rises.push_back(i);
        prev = w[i];
      end
      for (int k = 1; k < rises.size(); k++) begin
        int t;
        int ones;
        t = rises[k] + SYNC_STAGES;
        if (rises[k] - rises[k-1] == PERIOD) begin
          ones = 0;
          for (int j = rises[k-1]; j < rises[k]; j++) ones += int'(w[j]);
          ev[t] = 1;
          exp_q.push_back(ones[7:0]);
        end else begin
          ev[t] = 2;
        end
      end

      exp_locked = 1'b0;
      for (int i = 0; i < w.size(); i++) begin
        tick(w[i]);
        check("rnd_valid", duty_valid, ev[i] == 1);
        check("rnd_perr",  period_error, ev[i] == 2);
        if (ev[i] == 1) exp_locked = 1'b1;
        else if (ev[i] == 2) exp_locked = 1'b0;
        check("rnd_locked", locked, exp_locked);
        if (duty_valid) begin
          check("rnd_q_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("rnd_duty", duty_out, exp_q.pop_front());
        end
      end
      check("rnd_q_drained", exp_q.size(), 0);
    end

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
